// File: rtl/req_encoder8_3_if.sv
// rtl/req_encoder8_3_if.sv - valid/ready index channel from the request encoder
interface req_encoder8_3_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/req_encoder8_3.sv
// rtl/req_encoder8_3.sv - registered 8-to-3 request encoder with sticky pending bits
module req_encoder8_3 #(
    parameter bit RR = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [7:0]               req_in,
    req_encoder8_3_if.master         out_bus,
    output logic [7:0]               pending,
    output logic                     any_pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state;
    logic       valid_q;
    logic [2:0] idx_q;
    logic [2:0] rr_ptr;

    logic       accept;
    logic [7:0] clr_mask;
    logic [7:0] nxt;
    logic [2:0] ptr_acc;
    logic [2:0] sel_idle;
    logic [2:0] sel_nxt;

    // Rotate so that the scan start sits at bit 0, then pick the lowest set bit.
    function automatic logic [2:0] sel(input logic [7:0] p, input logic [2:0] ptr);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  k;
        dbl = {p, p};
        rot = RR ? 8'(dbl >> ptr) : p;
        k   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) k = 3'(i);
        end
        return RR ? 3'(k + ptr) : k;
    endfunction

    assign out_bus.out_valid = valid_q;
    assign out_bus.out_idx   = idx_q;
    assign any_pending       = |pending;

    always_comb begin
        accept   = valid_q & out_bus.out_ready;
        clr_mask = accept ? (8'b1 << idx_q) : 8'h00;
        // Next candidates exclude this edge's req_in so the served bit is never re-picked at once.
        nxt      = pending & ~clr_mask;
        ptr_acc  = RR ? 3'(idx_q + 3'd1) : 3'd0;
        sel_idle = sel(pending, rr_ptr);
        sel_nxt  = sel(nxt, ptr_acc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 8'h00;
            valid_q <= 1'b0;
            idx_q   <= 3'd0;
            rr_ptr  <= 3'd0;
            state   <= IDLE;
        end else if (flush) begin
            pending <= 8'h00;
            valid_q <= 1'b0;
            state   <= IDLE;
        end else begin
            // Set wins over clear: a re-request of the served bit stays pending.
            pending <= nxt | (enable ? req_in : 8'h00);
            if (accept && RR) begin
                rr_ptr <= ptr_acc;
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        idx_q   <= sel_idle;
                        valid_q <= 1'b1;
                        state   <= OFFER;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        if (|nxt) begin
                            idx_q <= sel_nxt;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder8_3.sv
// tb/tb_req_encoder8_3.sv - scoreboard bench running round-robin and fixed-priority encoders side by side
module tb_req_encoder8_3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush;
    logic [7:0] req_in;
    logic       ready;

    logic [7:0] pend_rr, pend_fp;
    logic       anyp_rr, anyp_fp;

    req_encoder8_3_if bus_rr ();
    req_encoder8_3_if bus_fp ();

    assign bus_rr.out_ready = ready;
    assign bus_fp.out_ready = ready;

    always #5 clk = ~clk;

    req_encoder8_3 #(.RR(1'b1)) dut_rr (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .req_in      (req_in),
        .out_bus     (bus_rr),
        .pending     (pend_rr),
        .any_pending (anyp_rr)
    );

    req_encoder8_3 #(.RR(1'b0)) dut_fp (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .req_in      (req_in),
        .out_bus     (bus_fp),
        .pending     (pend_fp),
        .any_pending (anyp_fp)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 is the round-robin instance, index 1 fixed priority.
    logic [7:0] m_pend  [2];
    bit         m_valid [2];
    int         m_idx   [2];
    int         m_ptr   [2];
    int         q0[$], q1[$];
    int         acc0[$], acc1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_sel(input logic [7:0] p, input int start);
        for (int k = 0; k < 8; k++) begin
            int b;
            b = (start + k) % 8;
            if (p[b]) return b;
        end
        return -1;
    endfunction

    task automatic qpush(input int i, input int v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qdel(input int i);
        if (i == 0) begin
            if (q0.size() > 0) void'(q0.pop_front());
        end else begin
            if (q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_edge(input int i);
        bit         acc;
        bit         rr;
        logic [7:0] old;
        logic [7:0] clr;
        logic [7:0] rest;
        rr  = (i == 0);
        acc = m_valid[i] && ready;
        if (flush) begin
            if (m_valid[i] && !acc) qdel(i);
            m_pend[i]  = 8'h00;
            m_valid[i] = 1'b0;
            return;
        end
        old = m_pend[i];
        clr = 8'h00;
        if (acc) begin
            clr[m_idx[i]] = 1'b1;
            if (rr) m_ptr[i] = (m_idx[i] + 1) % 8;
        end
        rest      = old & ~clr;
        m_pend[i] = rest | (enable ? req_in : 8'h00);
        if (!m_valid[i]) begin
            if (old != 8'h00) begin
                m_idx[i]   = ref_sel(old, rr ? m_ptr[i] : 0);
                m_valid[i] = 1'b1;
                qpush(i, m_idx[i]);
            end
        end else if (acc) begin
            if (rest != 8'h00) begin
                m_idx[i] = ref_sel(rest, rr ? m_ptr[i] : 0);
                qpush(i, m_idx[i]);
            end else begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic monitor(input int i, input logic v, input logic [2:0] idx,
                           input logic [7:0] p, input logic anyp);
        string tag;
        tag = (i == 0) ? "rr" : "fp";
        check({tag, ".out_valid"}, 32'(v), 32'(m_valid[i]));
        check({tag, ".pending"}, 32'(p), 32'(m_pend[i]));
        check({tag, ".any_pending"}, 32'(anyp), 32'(m_pend[i] != 8'h00));
        if (v === 1'b1) begin
            if (qsize(i) == 0) begin
                check({tag, ".unexpected_offer"}, 32'(idx), 32'hFFFF_FFFF);
            end else begin
                check({tag, ".out_idx"}, 32'(idx), 32'(qfront(i)));
                if (ready) begin
                    if (i == 0) acc0.push_back(int'(idx)); else acc1.push_back(int'(idx));
                    qdel(i);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            monitor(0, bus_rr.out_valid, bus_rr.out_idx, pend_rr, anyp_rr);
            monitor(1, bus_fp.out_valid, bus_fp.out_idx, pend_fp, anyp_fp);
        end
    end

    task automatic cycle(input logic [7:0] r, input logic en, input logic rdy, input logic fl);
        req_in = r;
        enable = en;
        ready  = rdy;
        flush  = fl;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ready  = 1'b0;
        req_in = 8'h00;
        enable = 1'b0;
        flush  = 1'b0;
        #2;
        check("reset.rr_valid", 32'(bus_rr.out_valid), 32'd0);
        check("reset.fp_valid", 32'(bus_fp.out_valid), 32'd0);
        check("reset.rr_pending", 32'(pend_rr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = 8'h00;
            m_valid[i] = 1'b0;
            m_idx[i]   = 0;
            m_ptr[i]   = 0;
        end
        q0.delete(); q1.delete(); acc0.delete(); acc1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single request: pending after edge 1, offer after edge 2, accept on edge 3.
        cycle(8'h04, 1'b1, 1'b1, 1'b0);
        check("t1.pending_e1", 32'(pend_rr), 32'h04);
        check("t1.valid_e1", 32'(bus_rr.out_valid), 32'd0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t1.valid_e2", 32'(bus_rr.out_valid), 32'd1);
        check("t1.idx_e2", 32'(bus_rr.out_idx), 32'd2);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t1.valid_e3", 32'(bus_rr.out_valid), 32'd0);
        check("t1.pending_e3", 32'(pend_rr), 32'd0);

        // All eight lines at once drain in order 0..7 for both arbitration modes.
        do_reset();
        cycle(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (10) cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t2.rr_count", 32'(acc0.size()), 32'd8);
        check("t2.fp_count", 32'(acc1.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < acc0.size()) check("t2.rr_order", 32'(acc0[k]), 32'(k));
            if (k < acc1.size()) check("t2.fp_order", 32'(acc1[k]), 32'(k));
        end
        check("t2.rr_valid_end", 32'(bus_rr.out_valid), 32'd0);

        // Stalled offer holds even when a higher-priority line arrives.
        do_reset();
        cycle(8'h20, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h02, 1'b1, 1'b0, 1'b0);
        check("t3.rr_hold", 32'(bus_rr.out_idx), 32'd5);
        check("t3.fp_hold", 32'(bus_fp.out_idx), 32'd5);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t3.rr_next", 32'(bus_rr.out_idx), 32'd1);
        check("t3.fp_next", 32'(bus_fp.out_idx), 32'd1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t3.rr_valid_end", 32'(bus_rr.out_valid), 32'd0);

        // Re-request of the served bit on the accept edge keeps it pending.
        do_reset();
        cycle(8'h08, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check("t4.idx_first", 32'(bus_rr.out_idx), 32'd3);
        cycle(8'h08, 1'b1, 1'b1, 1'b0);
        check("t4.pending_kept", 32'(pend_rr), 32'h08);
        check("t4.valid_gap", 32'(bus_rr.out_valid), 32'd0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check("t4.reoffer", 32'(bus_rr.out_idx), 32'd3);
        cycle(8'h08, 1'b0, 1'b1, 1'b0);
        check("t4.disabled_clear", 32'(pend_fp), 32'h00);

        // Flush while offering, then asynchronous reset while offering.
        do_reset();
        cycle(8'hA5, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check("t5.pending_a5", 32'(pend_rr), 32'hA5);
        check("t5.valid_pre", 32'(bus_rr.out_valid), 32'd1);
        cycle(8'h18, 1'b1, 1'b0, 1'b1);
        check("t5.flush_pending", 32'(pend_rr), 32'd0);
        check("t5.flush_valid", 32'(bus_fp.out_valid), 32'd0);
        cycle(8'hA5, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check("t5.valid_again", 32'(bus_rr.out_valid), 32'd1);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] r;
            logic       en, rdy, fl;
            r   = 8'($urandom & $urandom);
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            fl  = !rdy && ($urandom_range(0, 59) == 0);
            cycle(r, en, rdy, fl);
        end
        repeat (20) cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t6.rr_drained", 32'(q0.size()), 32'd0);
        check("t6.fp_drained", 32'(q1.size()), 32'd0);
        check("t6.rr_idle", 32'(bus_rr.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
